// File: rtl/apb_slave_regfile.sv
// APB slave register file: NUM_REGS registers of PWDATA_WIDTH bits, with
// configurable wait states; define APB_SLAVE_REGFILE_RO_ID_EN to make the top register a read-only ID.
module apb_slave_regfile #(
  parameter int unsigned PADDR_WIDTH  = 32,
  parameter int unsigned PWDATA_WIDTH = 8,
  parameter int unsigned NUM_REGS     = 16,
  parameter int unsigned SLV_INDEX    = 0,
  parameter int unsigned WAIT_STATES  = 0
) (
  input  logic                    pclock,
  input  logic                    preset,
  input  logic [PADDR_WIDTH-1:0]  paddr,
  input  logic                    prwd,
  input  logic [PWDATA_WIDTH-1:0] pwdata,
  input  logic                    penable,
  input  logic [15:0]             psel,
  output logic [PWDATA_WIDTH-1:0] prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int unsigned IdxW = $clog2(NUM_REGS);

  typedef enum logic {StIdle, StAccess} state_e;

  state_e                  state_q;
  logic [3:0]              wait_q;
  logic [PADDR_WIDTH-1:0]  addr_q;
  logic                    write_q;
  logic [PWDATA_WIDTH-1:0] wdata_q;
  logic [PWDATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                    sel;
  logic [IdxW-1:0]         idx;
  logic                    addr_valid;
  logic                    ro_hit;
  logic                    err;
  logic                    commit;
  logic                    do_write;
  logic [PWDATA_WIDTH-1:0] rd_word;
  logic                    unused_psel;

  assign sel         = psel[SLV_INDEX];
  assign unused_psel = ^psel;
  assign idx         = addr_q[IdxW-1:0];
  // Upper address bits must all be zero, so out-of-range addresses never alias.
  assign addr_valid  = (addr_q >> IdxW) == '0;

`ifdef APB_SLAVE_REGFILE_RO_ID_EN
  assign ro_hit  = addr_valid && (idx == IdxW'(NUM_REGS - 1));
  assign rd_word = ro_hit ? PWDATA_WIDTH'('hA5) : regs_q[idx];
`else
  assign ro_hit  = 1'b0;
  assign rd_word = regs_q[idx];
`endif

  assign err      = !addr_valid || (write_q && ro_hit);
  assign pready   = (state_q == StAccess) && (wait_q == 4'd0);
  assign pslverr  = pready && err;
  assign prdata   = (pready && !write_q && addr_valid) ? rd_word : '0;
  assign commit   = pready && sel && penable;
  assign do_write = commit && write_q && !err;

  always_ff @(posedge pclock or posedge preset) begin
    if (preset) begin
      state_q <= StIdle;
      wait_q  <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sel && !penable) begin
            state_q <= StAccess;
            addr_q  <= paddr;
            write_q <= prwd;
            wdata_q <= pwdata;
            wait_q  <= 4'(WAIT_STATES);
          end
        end
        StAccess: begin
          // Abort takes priority over counting down or completing.
          if (!sel || !penable) begin
            state_q <= StIdle;
            wait_q  <= 4'd0;
          end else if (wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge pclock or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (do_write) begin
      regs_q[idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Table-driven bench: three slaves (0, 3 and 2 wait states) share one APB bus,
// plus hand-written abort and mid-transfer reset sequences.
module tb_apb_slave_regfile;

`ifdef APB_SLAVE_REGFILE_RO_ID_EN
  localparam bit RoId = 1'b1;
`else
  localparam bit RoId = 1'b0;
`endif
  localparam logic [7:0] Rd15 = RoId ? 8'hA5 : 8'h12;

  logic        pclock = 1'b0;
  logic        preset;
  logic [31:0] paddr;
  logic        prwd;
  logic [7:0]  pwdata;
  logic        penable;
  logic [15:0] psel;
  logic [7:0]  rd_v [3];
  logic [2:0]  rdy_v;
  logic [2:0]  err_v;

  int errors = 0;
  int checks = 0;

  always #5 pclock = ~pclock;

  apb_slave_regfile #(.SLV_INDEX(0), .WAIT_STATES(0)) u_s0 (
    .pclock(pclock), .preset(preset), .paddr(paddr), .prwd(prwd), .pwdata(pwdata),
    .penable(penable), .psel(psel), .prdata(rd_v[0]), .pready(rdy_v[0]), .pslverr(err_v[0])
  );
  apb_slave_regfile #(.SLV_INDEX(1), .WAIT_STATES(3)) u_s1 (
    .pclock(pclock), .preset(preset), .paddr(paddr), .prwd(prwd), .pwdata(pwdata),
    .penable(penable), .psel(psel), .prdata(rd_v[1]), .pready(rdy_v[1]), .pslverr(err_v[1])
  );
  apb_slave_regfile #(.SLV_INDEX(2), .WAIT_STATES(2)) u_s2 (
    .pclock(pclock), .preset(preset), .paddr(paddr), .prwd(prwd), .pwdata(pwdata),
    .penable(penable), .psel(psel), .prdata(rd_v[2]), .pready(rdy_v[2]), .pslverr(err_v[2])
  );

  typedef struct {
    int          s;
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp_rd;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One full transfer; rd/err are sampled in the cycle pready is high.
  task automatic xfer(input int s, input logic wr, input logic [31:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic err, output int cyc,
                      output logic ok);
    psel = 16'h0;
    psel[s] = 1'b1;
    penable = 1'b0;
    paddr = a;
    prwd = wr;
    pwdata = d;
    rd = 8'h0;
    err = 1'b0;
    ok = 1'b0;
    @(negedge pclock);
    check($sformatf("setup_pready s%0d a%0h", s, a), {31'b0, rdy_v[s]}, 32'd0);
    cyc = 1;
    @(posedge pclock); #1;
    penable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclock);
      cyc++;
      if (rdy_v[s]) begin
        rd = rd_v[s];
        err = err_v[s];
        ok = 1'b1;
        break;
      end
      @(posedge pclock); #1;
    end
    @(posedge pclock); #1;
    psel = 16'h0;
    penable = 1'b0;
  endtask

  task automatic run_read(input string name, input int s, input logic [31:0] a,
                          input logic [7:0] exp_rd, input int exp_cyc);
    logic [7:0] rd;
    logic       err;
    int         cyc;
    logic       ok;
    xfer(s, 1'b0, a, 8'h0, rd, err, cyc, ok);
    check({name, "_done"}, {31'b0, ok}, 32'd1);
    check({name, "_rdata"}, {24'b0, rd}, {24'b0, exp_rd});
    check({name, "_err"}, {31'b0, err}, 32'd0);
    check({name, "_cycles"}, cyc, exp_cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rd;
    logic       err;
    logic       ok;
    int         cyc;
    int         pulses;
    logic [7:0] exp;

    //          s  wr    addr          data   exp_rd exp_err exp_cyc
    vecs[0]  = '{0, 1'b1, 32'h2,        8'h3C, 8'h00, 1'b0,   2};
    vecs[1]  = '{0, 1'b0, 32'h2,        8'h00, 8'h3C, 1'b0,   2};
    vecs[2]  = '{1, 1'b1, 32'h5,        8'h81, 8'h00, 1'b0,   5};
    vecs[3]  = '{1, 1'b0, 32'h5,        8'h00, 8'h81, 1'b0,   5};
    vecs[4]  = '{0, 1'b1, 32'h0,        8'h11, 8'h00, 1'b0,   2};
    vecs[5]  = '{0, 1'b1, 32'hF,        8'h12, 8'h00, RoId,   2};
    vecs[6]  = '{0, 1'b0, 32'hF,        8'h00, Rd15,  1'b0,   2};
    vecs[7]  = '{0, 1'b1, 32'h10,       8'hFF, 8'h00, 1'b1,   2};
    vecs[8]  = '{0, 1'b1, 32'h12,       8'hEE, 8'h00, 1'b1,   2};
    vecs[9]  = '{0, 1'b0, 32'h100,      8'h00, 8'h00, 1'b1,   2};
    vecs[10] = '{2, 1'b1, 32'h3,        8'hC3, 8'h00, 1'b0,   4};
    vecs[11] = '{2, 1'b0, 32'h3,        8'h00, 8'hC3, 1'b0,   4};
    vecs[12] = '{0, 1'b0, 32'h2,        8'h00, 8'h3C, 1'b0,   2};
    vecs[13] = '{1, 1'b0, 32'h2,        8'h00, 8'h00, 1'b0,   5};

    preset = 1'b1;
    paddr = 32'h0;
    prwd = 1'b0;
    pwdata = 8'h0;
    penable = 1'b0;
    psel = 16'h0;
    repeat (2) @(posedge pclock);
    @(negedge pclock);
    check("reset_pready", {29'b0, rdy_v}, 32'd0);
    check("reset_pslverr", {29'b0, err_v}, 32'd0);
    check("reset_prdata", {8'b0, rd_v[0], rd_v[1], rd_v[2]}, 32'd0);
    preset = 1'b0;
    @(posedge pclock); #1;

    // Back-to-back: each transfer starts in the cycle right after completion.
    for (int i = 0; i < 14; i++) begin
      xfer(vecs[i].s, vecs[i].wr, vecs[i].addr, vecs[i].data, rd, err, cyc, ok);
      check($sformatf("vec%0d_done", i), {31'b0, ok}, 32'd1);
      check($sformatf("vec%0d_rdata", i), {24'b0, rd}, {24'b0, vecs[i].exp_rd});
      check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cyc);
    end

    // Errored writes must not have disturbed any register.
    for (int a = 0; a < 16; a++) begin
      case (a)
        0:       exp = 8'h11;
        2:       exp = 8'h3C;
        15:      exp = Rd15;
        default: exp = 8'h00;
      endcase
      run_read($sformatf("scan%0d", a), 0, a, exp, 2);
    end

    // Abort: drop psel mid-wait on a write to slave 2.
    pulses = 0;
    psel = 16'h4;
    penable = 1'b0;
    paddr = 32'h1;
    prwd = 1'b1;
    pwdata = 8'h55;
    @(posedge pclock); #1;
    penable = 1'b1;
    @(negedge pclock);
    pulses += int'(rdy_v[2]);
    @(posedge pclock); #1;
    psel = 16'h0;
    penable = 1'b0;
    @(negedge pclock);
    pulses += int'(rdy_v[2]);
    repeat (3) begin
      @(negedge pclock);
      pulses += int'(rdy_v[2]);
    end
    check("abort_no_pready", pulses, 0);
    @(posedge pclock); #1;
    run_read("abort_reg1", 2, 32'h1, 8'h00, 4);

    // Reset during the ACCESS of a write to slave 0.
    psel = 16'h1;
    penable = 1'b0;
    paddr = 32'h4;
    prwd = 1'b1;
    pwdata = 8'h77;
    @(posedge pclock); #1;
    penable = 1'b1;
    @(negedge pclock);
    check("rst_pre_pready", {31'b0, rdy_v[0]}, 32'd1);
    preset = 1'b1;
    #1;
    check("rst_pready", {29'b0, rdy_v}, 32'd0);
    check("rst_pslverr", {29'b0, err_v}, 32'd0);
    check("rst_prdata", {24'b0, rd_v[0]}, 32'd0);
    @(posedge pclock); #1;
    psel = 16'h0;
    penable = 1'b0;
    @(negedge pclock);
    preset = 1'b0;
    @(posedge pclock); #1;
    run_read("post_rst_a4", 0, 32'h4, 8'h00, 2);
    run_read("post_rst_a2", 0, 32'h2, 8'h00, 2);
    run_read("post_rst_s1a5", 1, 32'h5, 8'h00, 5);
    run_read("post_rst_a15", 0, 32'hF, RoId ? 8'hA5 : 8'h00, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
